poz_compare_seq: RTL
====================

Name: poz_compare_seq

Overview:
- Upstream/downstream wrapper stage for the 4-bit unsigned comparator POZ_COMPARE.
- Accepts operand pairs over a valid/ready handshake and drives them bit-wise onto the comparator inputs.
- Waits a programmable settle time, then samples the comparator's x/y/z outputs.
- Presents each result over an output valid/ready handshake and keeps running tallies of outcomes.
- Comparator contract: x = (a > b), y = (a < b), z = (a == b); exactly one of them is high.

Parameters:
- SETTLE_CYCLES, 1, cycles operands are held on the comparator before sampling (legal range 1..15).
- CNT_W, 8, width of each outcome counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_a  in  4  operand a, unsigned
- in_b  in  4  operand b, unsigned
- a_0, a_1, a_2, a_3  out  1 each  registered bits of a, to comparator
- b_0, b_1, b_2, b_3  out  1 each  registered bits of b, to comparator
- x, y, z  in  1 each  comparator results (gt, lt, eq)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_gt, out_lt, out_eq  out  1 each  sampled x, y, z
- out_a, out_b  out  4 each  operands belonging to the result
- cnt_gt, cnt_lt, cnt_eq  out  CNT_W each  saturating outcome counters
- clr_cnt  in  1  synchronous clear of counters and err
- err  out  1  sticky flag: sampled x/y/z was not one-hot

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FSM goes to IDLE and any in-flight transaction is dropped.
  - All outputs go to 0: a_*/b_*, out_*, counters, err.
  - in_ready=1 from the first cycle after reset is released.
- FSM states: IDLE, DRIVE, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: latch in_a onto a_3..a_0 and in_b onto b_3..b_0 (also into out_a/out_b); load timer=SETTLE_CYCLES-1; go to DRIVE.
- DRIVE:
  - in_ready=0.
  - When timer=0: register x, y, z into out_gt, out_lt, out_eq; update counters/err; go to HOLD.
  - Otherwise decrement timer.
- HOLD:
  - out_valid=1; out_* stay stable until the handshake completes.
  - On out_ready=1: go to IDLE. out_valid drops the next cycle; out_* keep their values.
- Latency: out_valid rises exactly SETTLE_CYCLES cycles after the in_valid/in_ready acceptance edge.
- Throughput: at most one transaction per SETTLE_CYCLES+2 cycles. in_ready is low in DRIVE and HOLD, so there is no overlap.
- a_*/b_* change only on an acceptance edge. They hold their values through DRIVE, HOLD and the following IDLE.
- Counter update at the sample edge:
  - One-hot sample: increment the matching counter by 1. It saturates at 2^CNT_W-1 and never wraps.
  - Non-one-hot sample (0, 2 or 3 bits high): set err; no counter changes; the raw bits are still presented on out_gt/out_lt/out_eq.
- clr_cnt=1: zeroes all counters and err on that edge. If it coincides with a sample edge, clear wins (result 0, err 0). clr_cnt does not affect the FSM or the out_* signals.
- in_valid while in_ready=0 is ignored; the upstream must hold it.
- out_ready outside HOLD has no effect.

Test Plan:
- SETTLE_CYCLES=1; send (a=7,b=3), (12,7), (15,9) with out_ready=1 -> out_gt=1 each; out_valid exactly 1 cycle after each accept; cnt_gt=3, others 0.
- Send (3,5), (7,9), (11,13), then (11,11), (8,8), (15,15) -> three results with out_lt=1, then three with out_eq=1; cnt_lt=3, cnt_eq=3; out_a/out_b match each pair; err=0.
- SETTLE_CYCLES=3, out_ready=0 for 5 cycles after out_valid -> out_valid rises 3 cycles after accept; out_* and a_*/b_* stay stable; in_ready=0 until the cycle after out_ready=1.
- CNT_W=2, send (7,3) five times -> cnt_gt=3 (saturated); then pulse clr_cnt -> all counters 0.
- Comparator model forced to x=1,y=1 for one transaction -> err=1 and stays set; counters unchanged; the next valid compare counts normally; clr_cnt clears err.
- Assert rst_n=0 during DRIVE of (12,7) -> next cycle IDLE, out_valid=0, a_*/b_*=0, counters 0, in_ready=1 once reset is released.

Source files
------------

// File: rtl/poz_compare_seq.sv
// poz_compare_seq: handshake wrapper that drives a 4-bit comparator, samples it after a settle delay and tallies outcomes
module poz_compare_seq #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             a_0,
  output logic             a_1,
  output logic             a_2,
  output logic             a_3,
  output logic             b_0,
  output logic             b_1,
  output logic             b_2,
  output logic             b_3,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_gt,
  output logic             out_lt,
  output logic             out_eq,
  output logic [3:0]       out_a,
  output logic [3:0]       out_b,
  output logic [CNT_W-1:0] cnt_gt,
  output logic [CNT_W-1:0] cnt_lt,
  output logic [CNT_W-1:0] cnt_eq,
  input  logic             clr_cnt,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;
  localparam logic [3:0] TLOAD = 4'(SETTLE_CYCLES - 1);
  state_t state_q, state_d;
  logic [3:0] timer_q, timer_d, a_q, a_d, b_q, b_d, oa_q, oa_d, ob_q, ob_d;
  logic [2:0] res_q, res_d;
  logic [CNT_W-1:0] cg_q, cg_d, cl_q, cl_d, ce_q, ce_d;
  logic err_q, err_d, sample, one_hot;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  assign sample = state_q == DRIVE && timer_q == 4'd0;
  assign one_hot = {x, y, z} == 3'b100 || {x, y, z} == 3'b010 || {x, y, z} == 3'b001;
  // Next state: handshake sequencing, settle timer, result capture and counter/err update with clear priority
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    a_d = a_q;
    b_d = b_q;
    oa_d = oa_q;
    ob_d = ob_q;
    res_d = res_q;
    cg_d = cg_q;
    cl_d = cl_q;
    ce_d = ce_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = in_a;
        b_d = in_b;
        oa_d = in_a;
        ob_d = in_b;
        timer_d = TLOAD;
        state_d = DRIVE;
      end
      DRIVE: if (timer_q == 4'd0) begin
        res_d = {x, y, z};
        state_d = HOLD;
      end else timer_d = timer_q - 4'd1;
      HOLD: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (sample) begin
      cg_d = (one_hot && x) ? sat_inc(cg_q) : cg_q;
      cl_d = (one_hot && y) ? sat_inc(cl_q) : cl_q;
      ce_d = (one_hot && z) ? sat_inc(ce_q) : ce_q;
      err_d = err_q | ~one_hot;
    end
    if (clr_cnt) begin
      cg_d = '0;
      cl_d = '0;
      ce_d = '0;
      err_d = 1'b0;
    end
  end
  // State register with synchronous active-low reset clearing everything
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      a_q <= '0;
      b_q <= '0;
      oa_q <= '0;
      ob_q <= '0;
      res_q <= '0;
      cg_q <= '0;
      cl_q <= '0;
      ce_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      a_q <= a_d;
      b_q <= b_d;
      oa_q <= oa_d;
      ob_q <= ob_d;
      res_q <= res_d;
      cg_q <= cg_d;
      cl_q <= cl_d;
      ce_q <= ce_d;
      err_q <= err_d;
    end
  end
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = state_q == HOLD;
  assign {a_3, a_2, a_1, a_0} = a_q;
  assign {b_3, b_2, b_1, b_0} = b_q;
  assign {out_gt, out_lt, out_eq} = res_q;
  assign out_a = oa_q;
  assign out_b = ob_q;
  assign cnt_gt = cg_q;
  assign cnt_lt = cl_q;
  assign cnt_eq = ce_q;
  assign err = err_q;
endmodule
